instr_prefetch_buffer: RTL and testbench

- Sequential instruction prefetch buffer between the processor's instruction port and the instruction cache's CPU-side port.
- While the core decodes, it fetches ahead at consecutive word addresses and holds the results in a small FIFO.
- Hits are served with one-cycle latency.
- A non-sequential request (branch, jump, trap) flushes the buffer and restarts prefetch at the new address.

---
 rtl/prefetch_pkg.sv | 24 ++
 rtl/prefetch_fifo.sv | 48 ++++
 rtl/instr_prefetch_buffer.sv | 147 ++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetch buffer.
// Cache-side FSM states, FIFO entry layout and FIFO count width helper.
package prefetch_pkg;

    localparam int XLEN     = 32;
    localparam int WORD_INC = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] adr;
        logic [XLEN-1:0] data;
    } entry_t;

    // Count must hold 0..DEPTH inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of prefetched {adr, data} words with push, pop, flush.
// Ports: clk, res, flush, push, push_entry, pop -> head (comb), count.
module prefetch_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Flush wins over a coincident push; DEPTH is a power of two so
    // the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (res || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !res)
            mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetch buffer between core fetch port and I-cache.
// Ports: clk, res; cpu_instr_{req,adr,gnt,rvalid,read}; instr_{req,adr,gnt,rvalid,read}.
module instr_prefetch_buffer
    import prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADR_W = 32
) (
    input  logic             clk,
    input  logic             res,
    input  logic             cpu_instr_req,
    input  logic [ADR_W-1:0] cpu_instr_adr,
    output logic             cpu_instr_gnt,
    output logic             cpu_instr_rvalid,
    output logic [ADR_W-1:0] cpu_instr_read,
    output logic             instr_req,
    output logic [ADR_W-1:0] instr_adr,
    input  logic             instr_gnt,
    input  logic             instr_rvalid,
    input  logic [ADR_W-1:0] instr_read
);

    localparam int CNT_W = cnt_w(DEPTH);

    state_t           state;
    state_t           state_n;
    logic             discard;
    logic             discard_n;
    logic             active;
    logic             active_n;
    logic [ADR_W-1:0] fetch_adr;
    logic [ADR_W-1:0] fetch_n;
    logic [ADR_W-1:0] pend_adr;
    logic [ADR_W-1:0] pend_n;
    logic             req_n;
    logic [ADR_W-1:0] adr_n;

    logic [CNT_W-1:0] count;
    entry_t           head;
    entry_t           push_entry;
    logic [ADR_W-1:0] exp_adr;
    logic             pending;
    logic             hit;
    logic             flush;
    logic             push;

    assign push_entry = '{adr: pend_adr, data: instr_read};

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .res        (res),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (hit),
        .head       (head),
        .count      (count)
    );

    // Address the core is expected to ask for next, given what is
    // buffered or in flight.
    always_comb begin
        pending = (state != IDLE);
        if (count != '0)
            exp_adr = head.adr;
        else if (state == WAIT && !discard)
            exp_adr = pend_adr;
        else
            exp_adr = fetch_adr;
        hit   = cpu_instr_req && (count != '0)
                && (head.adr == cpu_instr_adr);
        flush = cpu_instr_req
                && (!active || (cpu_instr_adr != exp_adr));
        push  = (state == WAIT) && instr_rvalid && !discard;
    end

    assign cpu_instr_gnt = hit;

    always_comb begin
        state_n   = state;
        discard_n = discard;
        active_n  = active || flush;
        fetch_n   = flush ? cpu_instr_adr : fetch_adr;
        pend_n    = pend_adr;
        req_n     = instr_req;
        adr_n     = instr_adr;
        if (flush && pending)
            discard_n = 1'b1;
        unique case (state)
            IDLE: begin
                // A flush restarts fetch in the same cycle, with the
                // FIFO treated as already empty.
                if ((active || flush) && !discard
                    && (flush || count < CNT_W'(DEPTH))) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    adr_n   = fetch_n;
                end
            end
            REQ: begin
                if (instr_gnt) begin
                    state_n = WAIT;
                    req_n   = 1'b0;
                    pend_n  = instr_adr;
                    // A redirected stream keeps its new start address.
                    if (!discard && !flush)
                        fetch_n = fetch_adr + ADR_W'(WORD_INC);
                end
            end
            WAIT: begin
                if (instr_rvalid) begin
                    state_n   = IDLE;
                    discard_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state            <= IDLE;
            discard          <= 1'b0;
            active           <= 1'b0;
            fetch_adr        <= '0;
            pend_adr         <= '0;
            instr_req        <= 1'b0;
            instr_adr        <= '0;
            cpu_instr_rvalid <= 1'b0;
            cpu_instr_read   <= '0;
        end else begin
            state            <= state_n;
            discard          <= discard_n;
            active           <= active_n;
            fetch_adr        <= fetch_n;
            pend_adr         <= pend_n;
            instr_req        <= req_n;
            instr_adr        <= adr_n;
            cpu_instr_rvalid <= hit;
            if (hit)
                cpu_instr_read <= head.data;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer with a reactive cache model.
// Expected core data is queued at request time and popped on rvalid.
module tb_instr_prefetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] KEY   = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        cpu_instr_req = 1'b0;
    logic [31:0] cpu_instr_adr = '0;
    logic        cpu_instr_gnt;
    logic        cpu_instr_rvalid;
    logic [31:0] cpu_instr_read;
    logic        instr_req;
    logic [31:0] instr_adr;
    logic        instr_gnt = 1'b0;
    logic        instr_rvalid = 1'b0;
    logic [31:0] instr_read = '0;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int n_fetch = 0;

    logic [31:0] sb [$];
    logic [31:0] cache_log [$];

    int          cyc = 0;
    int          hold_until = 0;
    int          rv_lat = 1;
    int          rv_cnt = 0;
    int          n_rv = 0;
    int          unstable = 0;
    logic [31:0] rv_adr = '0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_adr = '0;

    instr_prefetch_buffer #(
        .DEPTH (DEPTH),
        .ADR_W (32)
    ) dut (
        .clk              (clk),
        .res              (res),
        .cpu_instr_req    (cpu_instr_req),
        .cpu_instr_adr    (cpu_instr_adr),
        .cpu_instr_gnt    (cpu_instr_gnt),
        .cpu_instr_rvalid (cpu_instr_rvalid),
        .cpu_instr_read   (cpu_instr_read),
        .instr_req        (instr_req),
        .instr_adr        (instr_adr),
        .instr_gnt        (instr_gnt),
        .instr_rvalid     (instr_rvalid),
        .instr_read       (instr_read)
    );

    always #5 clk = ~clk;

    // Cache: grants when not held off, answers rv_lat cycles later
    // with adr^KEY. Also counts core rvalids and request stability.
    always @(negedge clk) begin
        cyc++;
        if (cpu_instr_rvalid === 1'b1)
            n_rv++;
        if (prev_wait && (instr_req !== 1'b1 || instr_adr !== prev_adr))
            unstable++;
        instr_rvalid = 1'b0;
        instr_read   = '0;
        if (rv_cnt == 1) begin
            instr_rvalid = 1'b1;
            instr_read   = rv_adr ^ KEY;
        end
        if (rv_cnt > 0)
            rv_cnt--;
        instr_gnt = 1'b0;
        if (instr_req === 1'b1 && cyc >= hold_until) begin
            instr_gnt = 1'b1;
            cache_log.push_back(instr_adr);
            rv_adr = instr_adr;
            rv_cnt = rv_lat;
        end
        prev_wait = (instr_req === 1'b1) && !instr_gnt;
        prev_adr  = instr_adr;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] adr, input int max_w,
                         output int waited);
        logic [31:0] e;
        cpu_instr_req = 1'b1;
        cpu_instr_adr = adr;
        sb.push_back(adr ^ KEY);
        waited = 0;
        #1;
        while (cpu_instr_gnt !== 1'b1 && waited < max_w) begin
            @(posedge clk);
            #2;
            waited++;
        end
        chk($sformatf("gnt_%h", adr), {31'b0, cpu_instr_gnt}, 32'd1);
        if (cpu_instr_gnt === 1'b1)
            n_fetch++;
        @(posedge clk);
        #1;
        cpu_instr_req = 1'b0;
        e = sb.pop_front();
        chk($sformatf("rvalid_%h", adr), {31'b0, cpu_instr_rvalid}, 32'd1);
        chk($sformatf("data_%h", adr), cpu_instr_read, e);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_instr_req"}, {31'b0, instr_req}, 32'd0);
        chk({tag, "_instr_adr"}, instr_adr, 32'd0);
        chk({tag, "_cpu_gnt"}, {31'b0, cpu_instr_gnt}, 32'd0);
        chk({tag, "_cpu_rvalid"}, {31'b0, cpu_instr_rvalid}, 32'd0);
        chk({tag, "_cpu_read"}, cpu_instr_read, 32'd0);
    endtask

    initial begin
        int w;
        int b;
        int n;

        res = 1'b1;
        tick(3);
        chk_zero("reset");
        res = 1'b0;
        tick(1);

        // cold miss, then let the buffer fill up
        fetch(32'h0, 10, w);
        chk("miss_latency", w, 3);
        tick(20);
        chk("full_req_low", {31'b0, instr_req}, 32'd0);
        chk("full_words", 32'(cache_log.size()), 32'(1 + DEPTH));
        for (int i = 0; i <= DEPTH; i++)
            chk($sformatf("seq_log_%0d", i), cache_log[i], 32'(i * 4));

        // one pop allows exactly one more cache request
        fetch(32'h4, 2, w);
        chk("hit_4_wait", w, 0);
        tick(10);
        chk("refill_one", 32'(cache_log.size()), 32'd6);
        chk("refill_adr", cache_log[5], 32'h14);
        fetch(32'h8, 2, w);
        chk("hit_8_wait", w, 0);
        fetch(32'hC, 2, w);
        chk("hit_c_wait", w, 0);
        tick(20);
        chk("stream_words", 32'(cache_log.size()), 32'd8);
        chk("stream_last", cache_log[7], 32'h1C);
        chk("stream_req_low", {31'b0, instr_req}, 32'd0);

        // branch away from a full buffer
        b = cache_log.size();
        fetch(32'h100, 10, w);
        chk("branch_wait", w, 3);
        chk("branch_adr", cache_log[b], 32'h100);
        fetch(32'h104, 10, w);
        chk("after_branch_wait", w, 2);

        // jump while the 0x108 request is held off by the cache
        hold_until = cyc + 6;
        chk("req_held", {31'b0, instr_req}, 32'd1);
        chk("req_held_adr", instr_adr, 32'h108);
        b = cache_log.size();
        fetch(32'h40, 30, w);
        chk("jump_wait", w, 10);
        chk("jump_old_adr", cache_log[b], 32'h108);
        chk("jump_new_adr", cache_log[b+1], 32'h40);

        // address wrap
        tick(20);
        b = cache_log.size();
        fetch(32'hFFFFFFF8, 10, w);
        chk("wrap_f8_wait", w, 3);
        fetch(32'hFFFFFFFC, 10, w);
        chk("wrap_fc_wait", w, 2);
        fetch(32'h0, 10, w);
        chk("wrap_0_wait", w, 2);
        chk("wrap_log0", cache_log[b], 32'hFFFFFFF8);
        chk("wrap_log1", cache_log[b+1], 32'hFFFFFFFC);
        chk("wrap_log2", cache_log[b+2], 32'h0);

        // reset while a cache response is outstanding
        rv_lat = 3;
        n = 0;
        while (instr_req !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        chk("pre_reset_req", {31'b0, instr_req}, 32'd1);
        tick(1);
        res = 1'b1;
        tick(1);
        res = 1'b0;
        b = cache_log.size();
        chk_zero("midreset");
        tick(6);
        chk("post_reset_req", {31'b0, instr_req}, 32'd0);
        chk("post_reset_rvalid", {31'b0, cpu_instr_rvalid}, 32'd0);
        chk("post_reset_log", 32'(cache_log.size()), 32'(b));
        rv_lat = 1;
        fetch(32'h200, 10, w);
        chk("fresh_wait", w, 3);
        chk("fresh_adr", cache_log[b], 32'h200);

        tick(2);
        chk("rvalid_count", 32'(n_rv), 32'(n_fetch));
        chk("req_stable", 32'(unstable), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
